// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// default geometry, mul/div FSM encoding and stall-bus width helper.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;

  localparam int DEF_NUM_STAGES = int'(STAGE_WB) + 1;
  localparam int DEF_MD_STAGE   = int'(STAGE_EX);
  localparam int DEF_CNT_W      = 6;
  localparam int DEF_IDX_W      = 3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Stall bus carries one hold bit for the PC plus one per stage output register.
  function automatic int stall_bus_w(input int num_stages);
    return num_stages + 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages (master) and the
// hazard controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int IDX_W      = DEF_IDX_W
) ();

  logic [NUM_STAGES-1:0]              stallreq;
  logic                               md_start;
  logic [CNT_W-1:0]                   md_cycles;
  logic                               exc_req;
  logic [IDX_W-1:0]                   exc_stage;
  logic [31:0]                        exc_pc;
  logic                               perf_clr;

  logic [stall_bus_w(NUM_STAGES)-1:0] stall;
  logic [NUM_STAGES-1:0]              flush;
  logic                               new_pc_valid;
  logic [31:0]                        new_pc;
  logic                               md_busy;
  logic                               md_done;
  logic [31:0]                        stall_cycles;

  modport master (
    output stallreq, md_start, md_cycles, exc_req, exc_stage, exc_pc, perf_clr,
    input  stall, flush, new_pc_valid, new_pc, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  stallreq, md_start, md_cycles, exc_req, exc_stage, exc_pc, perf_clr,
    output stall, flush, new_pc_valid, new_pc, md_busy, md_done, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_md_busy_fsm.sv
// Multi-cycle mul/div occupancy tracker: IDLE -> BUSY (counting) -> DONE,
// with an abort input that returns to IDLE and suppresses the done pulse.
module md_busy_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cycles_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_val;

  // Counter holds the BUSY cycles still to run, including the current one.
  assign load_val = (cycles_i == '0) ? '0 : cycles_i - CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else if (start_i) begin
          cnt_d   = load_val;
          state_d = (load_val == '0) ? MD_DONE : MD_BUSY;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE) && !abort_i;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall bus, exception flush/redirect,
// mul/div busy tracking and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int MD_STAGE   = DEF_MD_STAGE,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int IDX_W      = DEF_IDX_W
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctrl
);

  localparam int STALL_W = stall_bus_w(NUM_STAGES);

  logic                  md_busy;
  logic                  md_done;
  logic                  md_abort;
  int                    exc_idx;
  logic [NUM_STAGES-1:0] req;
  logic                  hold;
  logic [STALL_W-1:0]    stall;
  logic [NUM_STAGES-1:0] flush;
  logic [31:0]           perf_q, perf_d;

  always_comb begin
    exc_idx = int'(ctrl.exc_stage);
    if (exc_idx > NUM_STAGES - 1) exc_idx = NUM_STAGES - 1;
  end

  // An exception squashing the mul/div stage kills the op and blocks a new issue.
  assign md_abort = ctrl.exc_req && (exc_idx >= MD_STAGE);

  md_busy_fsm #(
    .CNT_W(CNT_W)
  ) u_md_busy_fsm (
    .clk     (clk),
    .rst     (rst),
    .start_i (ctrl.md_start),
    .cycles_i(ctrl.md_cycles),
    .abort_i (md_abort),
    .busy_o  (md_busy),
    .done_o  (md_done)
  );

  // Hold everything up to and including the register after the oldest requester.
  always_comb begin
    req           = ctrl.stallreq;
    req[MD_STAGE] = req[MD_STAGE] | md_busy;
    hold          = 1'b0;
    stall         = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      hold         = hold | req[i];
      stall[i+1]   = hold;
    end
    stall[0] = hold;

    flush = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      flush[i] = ctrl.exc_req && (i <= exc_idx);
    end

    if (ctrl.exc_req || rst) stall = '0;
    if (rst) flush = '0;
  end

  always_comb begin
    perf_d = perf_q;
    if (ctrl.perf_clr) begin
      perf_d = '0;
    end else if ((|stall) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign ctrl.stall        = stall;
  assign ctrl.flush        = flush;
  assign ctrl.new_pc_valid = ctrl.exc_req && !rst;
  assign ctrl.new_pc       = (ctrl.exc_req && !rst) ? ctrl.exc_pc : 32'd0;
  assign ctrl.md_busy      = md_busy;
  assign ctrl.md_done      = md_done;
  assign ctrl.stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// reset/saturation sequences and randomized traffic against a timestamp model.
module tb_pipe_ctrl;

  localparam int N     = 5;
  localparam int MD    = 2;
  localparam int CNT_W = 6;
  localparam int IDX_W = 3;

  typedef struct {
    logic [N-1:0]       sr;
    logic               ms;
    logic [CNT_W-1:0]   mc;
    logic               er;
    logic [IDX_W-1:0]   es;
    logic [31:0]        pc;
    logic               clr;
    logic [N:0]         x_stall;
    logic [N-1:0]       x_flush;
    logic               x_busy;
    logic               x_done;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  pipe_ctrl #(
    .NUM_STAGES(N), .MD_STAGE(MD), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an op accepted at cycle t with latency L completes at t+max(L,1).
  int          m_cyc;
  int          m_done_at;
  longint      m_perf;
  logic [N:0]  e_stall;
  logic [N-1:0] e_flush;
  logic        e_busy, e_done, e_npv, e_abort;
  logic [31:0] e_npc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc     = 0;
    m_done_at = -1;
    m_perf    = 0;
  endtask

  task automatic model_eval();
    int k;
    int clamp;
    logic [N-1:0] r;
    e_busy  = (m_done_at > m_cyc);
    clamp   = (int'(bus.exc_stage) > N - 1) ? N - 1 : int'(bus.exc_stage);
    e_abort = bus.exc_req && (clamp >= MD);
    e_done  = (m_done_at == m_cyc) && !e_abort;
    r = bus.stallreq;
    if (e_busy) r[MD] = 1'b1;
    k = -1;
    for (int i = 0; i < N; i++) if (r[i]) k = i;
    e_stall = (bus.exc_req || k < 0) ? '0 : (N+1)'((1 << (k + 2)) - 1);
    e_flush = bus.exc_req ? N'((1 << (clamp + 1)) - 1) : '0;
    e_npv   = bus.exc_req;
    e_npc   = bus.exc_req ? bus.exc_pc : 32'd0;
  endtask

  task automatic model_step();
    if (bus.md_start && !e_busy && !e_abort)
      m_done_at = m_cyc + ((bus.md_cycles == 0) ? 1 : int'(bus.md_cycles));
    else if (e_abort)
      m_done_at = -1;
    if (bus.perf_clr) m_perf = 0;
    else if (e_stall != 0 && m_perf < 64'hFFFF_FFFF) m_perf++;
    m_cyc++;
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    bus.stallreq  = t.sr;
    bus.md_start  = t.ms;
    bus.md_cycles = t.mc;
    bus.exc_req   = t.er;
    bus.exc_stage = t.es;
    bus.exc_pc    = t.pc;
    bus.perf_clr  = t.clr;
    #1;
    model_eval();
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, ".stall"}, 64'(bus.stall), 64'(e_stall));
    check({tag, ".flush"}, 64'(bus.flush), 64'(e_flush));
    check({tag, ".npv"}, 64'(bus.new_pc_valid), 64'(e_npv));
    check({tag, ".new_pc"}, 64'(bus.new_pc), 64'(e_npc));
    check({tag, ".busy"}, 64'(bus.md_busy), 64'(e_busy));
    check({tag, ".done"}, 64'(bus.md_done), 64'(e_done));
    check({tag, ".perf"}, 64'(bus.stall_cycles), 64'(m_perf));
  endtask

  function automatic vec_t row(input logic [N-1:0] sr, input logic ms, input logic [CNT_W-1:0] mc,
                               input logic er, input logic [IDX_W-1:0] es, input logic [31:0] pc,
                               input logic clr, input logic [N:0] xs, input logic [N-1:0] xf,
                               input logic xb, input logic xd);
    vec_t t;
    t.sr = sr; t.ms = ms; t.mc = mc; t.er = er; t.es = es; t.pc = pc; t.clr = clr;
    t.x_stall = xs; t.x_flush = xf; t.x_busy = xb; t.x_done = xd;
    return t;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.stallreq  = '1;
    bus.md_start  = 1'b1;
    bus.md_cycles = 6'd3;
    bus.exc_req   = 1'b1;
    bus.exc_stage = 3'd2;
    bus.exc_pc    = 32'h1234_5678;
    bus.perf_clr  = 1'b0;
    #3;
    check("rst.stall", 64'(bus.stall), 64'd0);
    check("rst.flush", 64'(bus.flush), 64'd0);
    check("rst.npv", 64'(bus.new_pc_valid), 64'd0);
    check("rst.new_pc", 64'(bus.new_pc), 64'd0);
    check("rst.busy_done", 64'({bus.md_busy, bus.md_done}), 64'd0);
    check("rst.perf", 64'(bus.stall_cycles), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.stallreq = '0; bus.md_start = 1'b0; bus.exc_req = 1'b0; bus.exc_stage = '0;
    bus.exc_pc = '0; bus.md_cycles = '0;
    model_reset();
  endtask

  localparam logic [31:0] EPC = 32'hBFC0_0380;
  localparam logic [5:0]  S0 = 6'b000000, S_ID = 6'b000111, S_MD = 6'b001111, S_MEM = 6'b011111;

  vec_t tbl[$];
  vec_t rv;
  vec_t idle;

  initial begin
    n_checks = 0;
    n_err    = 0;
    do_reset();

    idle = row(0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0);
    // sr, ms, mc, er, es, pc, clr, exp_stall, exp_flush, busy, done
    tbl.push_back(idle);                                                        // 0
    tbl.push_back(row(5'b00010, 0, 0, 0, 0, 0, 0, S_ID, 0, 0, 0));              // 1 load-use
    tbl.push_back(row(5'b00010, 0, 0, 0, 0, 0, 0, S_ID, 0, 0, 0));              // 2
    tbl.push_back(row(0, 1, 4, 0, 0, 0, 0, S0, 0, 0, 0));                       // 3 start 4
    for (int i = 0; i < 3; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 1));                       // 7 done
    tbl.push_back(idle);                                                        // 8
    tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, S0, 0, 0, 0));                       // 9 start 0
    tbl.push_back(row(0, 1, 1, 0, 0, 0, 0, S0, 0, 0, 1));                       // 10 done + start 1
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 1));                       // 11 done
    tbl.push_back(idle);                                                        // 12
    tbl.push_back(row(0, 1, 8, 0, 0, 0, 0, S0, 0, 0, 0));                       // 13 start 8
    for (int i = 0; i < 2; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(row(5'b01000, 0, 0, 0, 0, 0, 0, S_MEM, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 1));                       // 21 done on time
    tbl.push_back(row(0, 1, 10, 0, 0, 0, 0, S0, 0, 0, 0));                      // 22 start 10
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));                     // 23
    tbl.push_back(row(0, 1, 1, 0, 0, 0, 0, S_MD, 0, 1, 0));                     // 24 start ignored
    for (int i = 0; i < 2; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 1, 3, EPC, 0, S0, 5'b01111, 1, 0));              // 27 abort
    for (int i = 0; i < 5; i++) tbl.push_back(idle);                            // 28..32 no done
    tbl.push_back(row(0, 1, 3, 0, 0, 0, 0, S0, 0, 0, 0));                       // 33 start 3
    tbl.push_back(row(0, 0, 0, 1, 1, 32'h100, 0, S0, 5'b00011, 1, 0));          // 34 young exc
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));                     // 35
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 1));                       // 36 done
    tbl.push_back(row(0, 1, 2, 1, 2, 32'h200, 0, S0, 5'b00111, 0, 0));          // 37 start killed
    tbl.push_back(idle);                                                        // 38
    tbl.push_back(row(0, 0, 0, 1, 7, 32'h300, 0, S0, 5'b11111, 0, 0));          // 39 clamp
    tbl.push_back(row(0, 1, 2, 0, 0, 0, 0, S0, 0, 0, 0));                       // 40 start 2
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, S_MD, 0, 1, 0));                     // 41
    tbl.push_back(row(0, 1, 5, 1, 4, 32'h400, 0, S0, 5'b11111, 0, 0));         // 42 done suppressed
    tbl.push_back(idle);                                                        // 43
    tbl.push_back(row(5'b00010, 0, 0, 0, 0, 0, 1, S_ID, 0, 0, 0));              // 44 clr wins
    tbl.push_back(idle);                                                        // 45
    tbl.push_back(row(5'b10000, 0, 0, 0, 0, 0, 0, 6'b111111, 0, 0, 0));         // 46 WB stall
    tbl.push_back(row(5'b00100, 0, 0, 1, 0, 32'h500, 0, S0, 5'b00001, 0, 0));   // 47 exc beats stall

    foreach (tbl[j]) begin
      drive(tbl[j]);
      check($sformatf("t%0d.stall", j), 64'(bus.stall), 64'(tbl[j].x_stall));
      check($sformatf("t%0d.flush", j), 64'(bus.flush), 64'(tbl[j].x_flush));
      check($sformatf("t%0d.npv", j), 64'(bus.new_pc_valid), 64'(tbl[j].er));
      check($sformatf("t%0d.new_pc", j), 64'(bus.new_pc), tbl[j].er ? 64'(tbl[j].pc) : 64'd0);
      check($sformatf("t%0d.busy", j), 64'(bus.md_busy), 64'(tbl[j].x_busy));
      check($sformatf("t%0d.done", j), 64'(bus.md_done), 64'(tbl[j].x_done));
      check($sformatf("t%0d.perf", j), 64'(bus.stall_cycles), 64'(m_perf));
      model_step();
    end

    // Async reset mid-BUSY once seven stall cycles have been counted.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(row(5'b00010, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0));
      check_vs_model("ar.pre");
      model_step();
    end
    drive(row(0, 1, 20, 0, 0, 0, 0, S0, 0, 0, 0));
    check_vs_model("ar.start");
    model_step();
    for (int i = 0; i < 4; i++) begin
      drive(idle);
      check_vs_model("ar.busy");
      model_step();
    end
    drive(row(5'b00010, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0));
    check("ar.perf7", 64'(bus.stall_cycles), 64'd7);
    check("ar.busy_before", 64'(bus.md_busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("ar.stall0", 64'(bus.stall), 64'd0);
    check("ar.perf0", 64'(bus.stall_cycles), 64'd0);
    check("ar.busy0", 64'(bus.md_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.stallreq = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(idle);
      check_vs_model("ar.post");
      model_step();
    end

    // Saturation: preload just below the ceiling, then stall three cycles.
    @(negedge clk);
    force dut.perf_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.perf_q;
    m_perf = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(row(5'b00010, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0));
      check_vs_model("sat");
      model_step();
    end
    drive(idle);
    check("sat.hold", 64'(bus.stall_cycles), 64'hFFFF_FFFF);
    model_step();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv.sr  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rv.ms  = ($urandom_range(0, 3) == 0);
      rv.mc  = CNT_W'($urandom_range(0, 9));
      rv.er  = ($urandom_range(0, 11) == 0);
      rv.es  = IDX_W'($urandom_range(0, 7));
      rv.pc  = $urandom;
      rv.clr = ($urandom_range(0, 39) == 0);
      drive(rv);
      check_vs_model($sformatf("rnd%0d", i));
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline hazard controller that generates the per-stage stall bus and flush vector for the N-stage in-order core. It extends the single load-use stall source to per-stage stall requests. It adds a multi-cycle mul/div busy FSM, exception-driven flush with redirect PC, and a saturating stall-cycle performance counter. It sits beside the stages in the core top and drives all stage pipeline registers.

Parameters:
NUM_STAGES, 5, pipeline stages (index 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB; higher index = older instruction)
MD_STAGE, 2, stage index that owns the long-latency mul/div unit
CNT_W, 6, width of the mul/div cycle count
IDX_W, 3, width of a stage index, ≥ clog2(NUM_STAGES)

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
stallreq  in  NUM_STAGES  per-stage combinational stall request (bit i from stage i)
md_start  in  1  mul/div op issued in MD_STAGE this cycle
md_cycles  in  CNT_W  latency of the issued op
exc_req  in  1  exception or redirect taken this cycle
exc_stage  in  IDX_W  stage index of the excepting instruction
exc_pc  in  32  handler/redirect target
perf_clr  in  1  synchronous clear of stall_cycles
stall  out  NUM_STAGES+1  bit 0 = PC register, bit i+1 = output register of stage i; 1 = hold
flush  out  NUM_STAGES  bit i = squash stage i contents this cycle
new_pc_valid  out  1  redirect PC to new_pc
new_pc  out  32  redirect target
md_busy  out  1  mul/div FSM in BUSY
md_done  out  1  one-cycle pulse: result valid this cycle
stall_cycles  out  32  saturating count of cycles with any stall bit set

Behaviour:
- Reset (async, rst=1): FSM=IDLE, counter=0, stall_cycles=0. While rst is high, all outputs are 0: stall, flush, new_pc_valid, new_pc, md_busy, md_done.
- Effective request r[i] = stallreq[i] | (i==MD_STAGE & md_state==BUSY).
- Stall vector, combinational: k = highest i with r[i]=1. stall[0..k+1]=1 and all higher bits=0. No request gives stall=0.
  - The next-older stage receives a bubble: stall[k+1]=1 and stall[k+2]=0. The stage itself inserts the NOP.
- Exception, combinational, highest priority:
  - exc_req=1 forces stall=0, flush[0..exc_stage]=1 and higher flush bits=0.
  - new_pc_valid=1, new_pc=exc_pc. Otherwise new_pc=0.
  - exc_stage ≥ NUM_STAGES is clamped to NUM_STAGES-1.
- Mul/div FSM, registered:
  - IDLE: md_start → BUSY, counter = max(md_cycles,1) - 1. If that value is 0, go directly to DONE next cycle.
  - BUSY: counter decrements each cycle. Counter==0 → DONE.
  - DONE: md_done=1 for exactly one cycle, no md stall request, then → IDLE. md_start in DONE is accepted, as in IDLE.
  - md_start in BUSY is ignored.
  - exc_req with exc_stage ≥ MD_STAGE in BUSY or DONE aborts to IDLE next cycle; md_done is suppressed that cycle. Exceptions from younger stages do not abort.
  - md_start while exc_req flushes MD_STAGE is ignored.
  - Exception abort takes precedence over counter expiry in the same cycle.
- Perf counter: stall_cycles increments when |stall and !perf_clr. It saturates at 0xFFFFFFFF. perf_clr has priority and loads 0.
- External stallreq from a stage older than MD_STAGE during BUSY does not pause the counter. The op completes and its stall merges with the older stall via the k rule.

Decomposition:
- Shared package/header: STAGE_IF..STAGE_WB index constants, StallBus width define, md FSM state encoding (IDLE=0, BUSY=1, DONE=2).
- One natural sub-module: md_busy_fsm (FSM + counter, abort input). Stall/flush priority logic stays in pipe_ctrl.

Test Plan:
- stallreq=5'b00010 (ID load-use), no exc → stall=6'b000111, flush=0, stall_cycles +1 per cycle.
- md_start, md_cycles=4 → md_busy for 3 cycles with stall=6'b001111, md_done pulse on 4th cycle with stall=0, then IDLE.
- md_cycles=0 and md_cycles=1 → md_done exactly one cycle after start, no stall cycles.
- BUSY with 5 cycles left, exc_req exc_stage=3, exc_pc=0xBFC00380 → that cycle stall=0, flush=5'b01111, new_pc=0xBFC00380. Next cycle IDLE, md_done never pulses.
- BUSY + stallreq[3]=1 → stall=6'b011111. Counter still expires on schedule; md_done fires.
- Assert rst asynchronously mid-BUSY with stall_cycles=7 → all outputs 0 immediately, stall_cycles=0, FSM IDLE after release; also preload 0xFFFFFFFE, stall 3 cycles → holds 0xFFFFFFFF.
